rob_commit_queue: RTL and testbench
===================================

Name: rob_commit_queue

Overview:
- Reorder buffer for the Tomasulo core. It is the producer side of the tags the reservation station consumes.
- Allocates a ROB id to each decoded instruction and answers the decoder's operand-dependency lookups.
- Captures results broadcast on the CDB.
- Retires entries in program order to the register file.
- Drives rob_full back to the decoder for dispatch stall.

Parameters:
- ROB_SIZE_BIT, 3, log2 of entry count (8 entries).
- ROB_SIZE, 1<<ROB_SIZE_BIT, entry count.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  synchronous active-high reset
- rdy_in  input  1  ready; state frozen when low
- flush_in  input  1  mispredict flush, clears all entries
- rob_full  output  1  no free entry; decoder must not allocate
- dec_valid  input  1  decoder allocates one entry this cycle
- dec_has_rd  input  1  instruction writes a register
- dec_rd  input  5  destination register
- dec_rob_id  output  ROB_SIZE_BIT  id the next allocation receives (current tail)
- q1_rob_id  input  ROB_SIZE_BIT  lookup id for rs1 dependency
- q1_ready  output  1  entry q1 holds its result
- q1_value  output  32  result of entry q1
- q2_rob_id  input  ROB_SIZE_BIT  lookup id for rs2 dependency
- q2_ready  output  1  entry q2 holds its result
- q2_value  output  32  result of entry q2
- cdb_valid  input  1  result broadcast valid
- cdb_rob_id  input  ROB_SIZE_BIT  tag of broadcast
- cdb_value  input  32  broadcast result
- commit_valid  output  1  one-cycle retire pulse
- commit_rob_id  output  ROB_SIZE_BIT  retired id
- commit_has_rd  output  1  retired instruction writes rd
- commit_rd  output  5  retired rd
- commit_value  output  32  retired value

Behaviour:
- Storage: circular buffer, head/tail pointers of ROB_SIZE_BIT bits (natural wrap), count of ROB_SIZE_BIT+1 bits.
- Per-entry fields: busy, ready, has_rd, rd, value.
- Priority: rst_in > rdy_in low > flush_in > normal operation.
- Reset: head = tail = count = 0, all busy/ready = 0, commit_* registers = 0. rob_full = 0, dec_rob_id = 0.
- rdy_in low: no register changes, except commit_valid is forced to 0 (no duplicate retire).
- Flush (rdy_in high): same clearing as reset; commit_valid = 0 that cycle. The same-cycle dec_valid and cdb_valid are dropped.
- rob_full: combinational, asserted when count == ROB_SIZE.
- Allocate (dec_valid && !rob_full):
  - Entry[tail] gets busy = 1, ready = 0, has_rd = dec_has_rd, rd = dec_rd.
  - tail increments by 1.
  - dec_valid while full is ignored; no state change.
- CDB capture: cdb_valid with entry[cdb_rob_id].busy sets ready = 1 and value = cdb_value. A broadcast to a non-busy entry is ignored.
- Commit:
  - Condition: entry[head].busy && entry[head].ready, evaluated on registered state.
  - Next edge: commit_* registers load entry[head] with commit_valid = 1, entry[head].busy is cleared, head increments by 1.
  - Otherwise commit_valid = 0.
  - At most one commit per cycle.
  - Latency: a CDB write at edge N produces the commit pulse after edge N+1, if that entry is at the head.
- Count: count_next = count + alloc - commit.
  - Simultaneous alloc and commit keep count unchanged.
  - When full, alloc stays blocked that cycle even if a commit frees a slot.
- Lookup (combinational, per port):
  - If cdb_valid && cdb_rob_id == qN_rob_id && entry busy: ready = 1, value = cdb_value (bypass).
  - Else ready = entry.ready, value = entry.value.
  - Non-busy entry gives ready = 0, value = 0.
- Wrap-around: head/tail roll from ROB_SIZE-1 to 0. Full vs empty is distinguished only by count.

Decomposition:
- Shared Config package: ROB_SIZE_BIT, ROB_SIZE, 32-bit data width, 5-bit register index width. The RS uses the same constants for its tag widths.
- One sub-module is natural: rob_lookup_port, the combinational dependency lookup with CDB bypass, instantiated twice (q1, q2).

Test Plan:
- Reset then idle: after rst_in high 1 cycle -> rob_full = 0, dec_rob_id = 0, commit_valid = 0 for 10 cycles.
- Allocate ids 0,1 (rd = 5, rd = 6); CDB id 1 = 0x22 then id 0 = 0x11 -> retire order:
  - pulse 1: id 0, rd 5, value 0x11;
  - next cycle pulse 2: id 1, rd 6, value 0x22.
- Fill 8 entries -> rob_full = 1; a 9th dec_valid is ignored (dec_rob_id stays 0). Resolve and commit id 0, then allocate -> new entry gets id 0, rob_full = 1 again.
- Lookup bypass: q1_rob_id = 2 while cdb_valid with id 2 = 0xDEADBEEF in the same cycle -> q1_ready = 1, q1_value = 0xDEADBEEF combinationally.
- rdy_in low for 3 cycles with pending CDB and ready head -> no commit pulse, pointers unchanged. Resume -> exactly one commit per ready entry.
- flush_in with 4 busy entries and a simultaneous dec_valid -> count = 0, dec_rob_id = 0, no commit pulse; a following allocation gets id 0.

Source files
------------

// File: rtl/rob_commit_queue_pkg.sv
// Shared reorder-buffer constants and types; the reservation station sizes its
// tags from the same constants.
package rob_commit_queue_pkg;

    localparam int unsigned ROB_SIZE_BIT = 3;
    localparam int unsigned ROB_SIZE     = 1 << ROB_SIZE_BIT;
    localparam int unsigned DATA_W       = 32;
    localparam int unsigned REG_W        = 5;

    typedef logic [ROB_SIZE_BIT-1:0] rob_id_t;
    typedef logic [ROB_SIZE_BIT:0]   rob_count_t;
    typedef logic [DATA_W-1:0]       data_t;
    typedef logic [REG_W-1:0]        reg_idx_t;

    localparam rob_count_t ROB_FULL_COUNT = rob_count_t'(ROB_SIZE);

    typedef struct packed {
        logic     busy;
        logic     ready;
        logic     has_rd;
        reg_idx_t rd;
        data_t    value;
    } rob_entry_t;

endpackage

// File: rtl/rob_lookup_port.sv
// Combinational operand-dependency lookup into the ROB, with same-cycle CDB bypass.
module rob_lookup_port
    import rob_commit_queue_pkg::*;
(
    input  rob_entry_t [ROB_SIZE-1:0] entries,
    input  rob_id_t                   rob_id,
    input  logic                      cdb_valid,
    input  rob_id_t                   cdb_rob_id,
    input  data_t                     cdb_value,
    output logic                      ready,
    output data_t                     value
);

    rob_entry_t entry;

    always_comb begin
        entry = entries[rob_id];
        ready = 1'b0;
        value = '0;
        if (entry.busy) begin
            // A result broadcast this cycle is visible before it lands in the entry.
            if (cdb_valid && (cdb_rob_id == rob_id)) begin
                ready = 1'b1;
                value = cdb_value;
            end else begin
                ready = entry.ready;
                value = entry.value;
            end
        end
    end

endmodule

// File: rtl/rob_commit_queue.sv
// Reorder buffer: in-order allocation, CDB result capture, in-order retirement.
module rob_commit_queue
    import rob_commit_queue_pkg::*;
(
    input  logic     clk_in,
    input  logic     rst_in,
    input  logic     rdy_in,
    input  logic     flush_in,
    output logic     rob_full,
    input  logic     dec_valid,
    input  logic     dec_has_rd,
    input  reg_idx_t dec_rd,
    output rob_id_t  dec_rob_id,
    input  rob_id_t  q1_rob_id,
    output logic     q1_ready,
    output data_t    q1_value,
    input  rob_id_t  q2_rob_id,
    output logic     q2_ready,
    output data_t    q2_value,
    input  logic     cdb_valid,
    input  rob_id_t  cdb_rob_id,
    input  data_t    cdb_value,
    output logic     commit_valid,
    output rob_id_t  commit_rob_id,
    output logic     commit_has_rd,
    output reg_idx_t commit_rd,
    output data_t    commit_value
);

    rob_entry_t [ROB_SIZE-1:0] entries_q, entries_d;
    rob_id_t    head_q, head_d;
    rob_id_t    tail_q, tail_d;
    rob_count_t count_q, count_d;

    logic     commit_valid_q, commit_valid_d;
    rob_id_t  commit_rob_id_q, commit_rob_id_d;
    logic     commit_has_rd_q, commit_has_rd_d;
    reg_idx_t commit_rd_q, commit_rd_d;
    data_t    commit_value_q, commit_value_d;

    logic do_alloc;
    logic do_commit;

    assign rob_full   = (count_q == ROB_FULL_COUNT);
    assign dec_rob_id = tail_q;

    // Full blocks allocation even when a commit frees a slot in the same cycle.
    assign do_alloc  = dec_valid && !rob_full;
    assign do_commit = entries_q[head_q].busy && entries_q[head_q].ready;

    always_comb begin
        entries_d       = entries_q;
        head_d          = head_q;
        tail_d          = tail_q;
        count_d         = count_q;
        commit_valid_d  = 1'b0;
        commit_rob_id_d = commit_rob_id_q;
        commit_has_rd_d = commit_has_rd_q;
        commit_rd_d     = commit_rd_q;
        commit_value_d  = commit_value_q;

        if (rdy_in) begin
            if (flush_in) begin
                entries_d       = '0;
                head_d          = '0;
                tail_d          = '0;
                count_d         = '0;
                commit_rob_id_d = '0;
                commit_has_rd_d = 1'b0;
                commit_rd_d     = '0;
                commit_value_d  = '0;
            end else begin
                if (cdb_valid && entries_q[cdb_rob_id].busy) begin
                    entries_d[cdb_rob_id].ready = 1'b1;
                    entries_d[cdb_rob_id].value = cdb_value;
                end

                if (do_commit) begin
                    commit_valid_d          = 1'b1;
                    commit_rob_id_d         = head_q;
                    commit_has_rd_d         = entries_q[head_q].has_rd;
                    commit_rd_d             = entries_q[head_q].rd;
                    commit_value_d          = entries_q[head_q].value;
                    entries_d[head_q].busy  = 1'b0;
                    head_d                  = head_q + rob_id_t'(1);
                end

                if (do_alloc) begin
                    entries_d[tail_q].busy   = 1'b1;
                    entries_d[tail_q].ready  = 1'b0;
                    entries_d[tail_q].has_rd = dec_has_rd;
                    entries_d[tail_q].rd     = dec_rd;
                    tail_d                   = tail_q + rob_id_t'(1);
                end

                count_d = count_q + rob_count_t'(do_alloc) - rob_count_t'(do_commit);
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            entries_q       <= '0;
            head_q          <= '0;
            tail_q          <= '0;
            count_q         <= '0;
            commit_valid_q  <= 1'b0;
            commit_rob_id_q <= '0;
            commit_has_rd_q <= 1'b0;
            commit_rd_q     <= '0;
            commit_value_q  <= '0;
        end else begin
            entries_q       <= entries_d;
            head_q          <= head_d;
            tail_q          <= tail_d;
            count_q         <= count_d;
            commit_valid_q  <= commit_valid_d;
            commit_rob_id_q <= commit_rob_id_d;
            commit_has_rd_q <= commit_has_rd_d;
            commit_rd_q     <= commit_rd_d;
            commit_value_q  <= commit_value_d;
        end
    end

    assign commit_valid  = commit_valid_q;
    assign commit_rob_id = commit_rob_id_q;
    assign commit_has_rd = commit_has_rd_q;
    assign commit_rd     = commit_rd_q;
    assign commit_value  = commit_value_q;

    rob_lookup_port u_lookup_q1 (
        .entries    (entries_q),
        .rob_id     (q1_rob_id),
        .cdb_valid  (cdb_valid),
        .cdb_rob_id (cdb_rob_id),
        .cdb_value  (cdb_value),
        .ready      (q1_ready),
        .value      (q1_value)
    );

    rob_lookup_port u_lookup_q2 (
        .entries    (entries_q),
        .rob_id     (q2_rob_id),
        .cdb_valid  (cdb_valid),
        .cdb_rob_id (cdb_rob_id),
        .cdb_value  (cdb_value),
        .ready      (q2_ready),
        .value      (q2_value)
    );

endmodule

// File: tb/tb_rob_commit_queue.sv
// Directed self-checking bench for rob_commit_queue.
module tb_rob_commit_queue;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, flush_in;
    logic        rob_full;
    logic        dec_valid, dec_has_rd;
    logic [4:0]  dec_rd;
    logic [2:0]  dec_rob_id;
    logic [2:0]  q1_rob_id, q2_rob_id;
    logic        q1_ready, q2_ready;
    logic [31:0] q1_value, q2_value;
    logic        cdb_valid;
    logic [2:0]  cdb_rob_id;
    logic [31:0] cdb_value;
    logic        commit_valid, commit_has_rd;
    logic [2:0]  commit_rob_id;
    logic [4:0]  commit_rd;
    logic [31:0] commit_value;

    int errors = 0;
    int checks = 0;

    always #5 clk_in = ~clk_in;

    rob_commit_queue dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .rdy_in        (rdy_in),
        .flush_in      (flush_in),
        .rob_full      (rob_full),
        .dec_valid     (dec_valid),
        .dec_has_rd    (dec_has_rd),
        .dec_rd        (dec_rd),
        .dec_rob_id    (dec_rob_id),
        .q1_rob_id     (q1_rob_id),
        .q1_ready      (q1_ready),
        .q1_value      (q1_value),
        .q2_rob_id     (q2_rob_id),
        .q2_ready      (q2_ready),
        .q2_value      (q2_value),
        .cdb_valid     (cdb_valid),
        .cdb_rob_id    (cdb_rob_id),
        .cdb_value     (cdb_value),
        .commit_valid  (commit_valid),
        .commit_rob_id (commit_rob_id),
        .commit_has_rd (commit_has_rd),
        .commit_rd     (commit_rd),
        .commit_value  (commit_value)
    );

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_in = 1'b1;
        step();
        rst_in = 1'b0;
    endtask

    task automatic expect_commit(input string tag, input logic [2:0] id,
                                 input logic [4:0] rd, input logic [31:0] val);
        chk({tag, "_valid"}, 32'(commit_valid), 32'd1);
        chk({tag, "_id"}, 32'(commit_rob_id), 32'(id));
        chk({tag, "_has_rd"}, 32'(commit_has_rd), 32'd1);
        chk({tag, "_rd"}, 32'(commit_rd), 32'(rd));
        chk({tag, "_value"}, commit_value, val);
    endtask

    initial begin
        rst_in = 1'b1; rdy_in = 1'b1; flush_in = 1'b0;
        dec_valid = 1'b0; dec_has_rd = 1'b0; dec_rd = '0;
        q1_rob_id = '0; q2_rob_id = '0;
        cdb_valid = 1'b0; cdb_rob_id = '0; cdb_value = '0;

        // Reset then idle
        do_reset();
        chk("rst_full", 32'(rob_full), 32'd0);
        chk("rst_dec_id", 32'(dec_rob_id), 32'd0);
        for (int i = 0; i < 10; i++) begin
            chk("idle_commit", 32'(commit_valid), 32'd0);
            step();
        end

        // Out-of-order completion, in-order retirement
        dec_valid = 1'b1; dec_has_rd = 1'b1; dec_rd = 5'd5;
        step();
        chk("alloc0_next_id", 32'(dec_rob_id), 32'd1);
        dec_rd = 5'd6;
        step();
        chk("alloc1_next_id", 32'(dec_rob_id), 32'd2);
        dec_valid = 1'b0;
        cdb_valid = 1'b1; cdb_rob_id = 3'd1; cdb_value = 32'h22;
        step();
        chk("ooo_no_commit_a", 32'(commit_valid), 32'd0);
        cdb_rob_id = 3'd0; cdb_value = 32'h11;
        step();
        chk("ooo_no_commit_b", 32'(commit_valid), 32'd0);
        cdb_valid = 1'b0;
        step();
        expect_commit("retire0", 3'd0, 5'd5, 32'h11);
        step();
        expect_commit("retire1", 3'd1, 5'd6, 32'h22);
        step();
        chk("retire_done", 32'(commit_valid), 32'd0);

        // Fill to full, reject extra allocation, free one slot and reuse id 0
        do_reset();
        dec_valid = 1'b1; dec_has_rd = 1'b1;
        for (int i = 0; i < 8; i++) begin
            dec_rd = 5'(i + 1);
            step();
        end
        chk("fill_full", 32'(rob_full), 32'd1);
        chk("fill_dec_id", 32'(dec_rob_id), 32'd0);
        step();
        chk("extra_full", 32'(rob_full), 32'd1);
        chk("extra_dec_id", 32'(dec_rob_id), 32'd0);
        dec_valid = 1'b0;
        cdb_valid = 1'b1; cdb_rob_id = 3'd0; cdb_value = 32'h100;
        step();
        cdb_valid = 1'b0;
        step();
        expect_commit("full_retire0", 3'd0, 5'd1, 32'h100);
        chk("after_free_full", 32'(rob_full), 32'd0);
        dec_valid = 1'b1; dec_rd = 5'd20;
        step();
        dec_valid = 1'b0;
        chk("realloc_next_id", 32'(dec_rob_id), 32'd1);
        chk("realloc_full", 32'(rob_full), 32'd1);
        chk("realloc_no_commit", 32'(commit_valid), 32'd0);

        // Same-cycle CDB bypass on lookup
        q1_rob_id = 3'd2; q2_rob_id = 3'd3;
        cdb_valid = 1'b1; cdb_rob_id = 3'd2; cdb_value = 32'hDEADBEEF;
        #1;
        chk("bypass_q1_ready", 32'(q1_ready), 32'd1);
        chk("bypass_q1_value", q1_value, 32'hDEADBEEF);
        chk("bypass_q2_ready", 32'(q2_ready), 32'd0);
        chk("bypass_q2_value", q2_value, 32'h0);
        step();
        cdb_valid = 1'b0;
        #1;
        chk("stored_q1_ready", 32'(q1_ready), 32'd1);
        chk("stored_q1_value", q1_value, 32'hDEADBEEF);

        // Freeze with a ready head and a pending broadcast
        cdb_valid = 1'b1; cdb_rob_id = 3'd1; cdb_value = 32'h1111;
        step();
        rdy_in = 1'b0;
        cdb_rob_id = 3'd3; cdb_value = 32'h3333;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("frozen_commit", 32'(commit_valid), 32'd0);
            chk("frozen_dec_id", 32'(dec_rob_id), 32'd1);
        end
        cdb_valid = 1'b0;
        rdy_in = 1'b1;
        #1;
        chk("frozen_cdb_dropped", 32'(q2_ready), 32'd0);
        step();
        expect_commit("resume_retire1", 3'd1, 5'd2, 32'h1111);
        step();
        expect_commit("resume_retire2", 3'd2, 5'd3, 32'hDEADBEEF);
        step();
        chk("resume_stop", 32'(commit_valid), 32'd0);
        chk("resume_full", 32'(rob_full), 32'd0);

        // Flush with four busy entries, a ready head and a simultaneous allocation
        do_reset();
        dec_valid = 1'b1; dec_has_rd = 1'b1; dec_rd = 5'd7;
        for (int i = 0; i < 4; i++) step();
        dec_valid = 1'b0;
        cdb_valid = 1'b1; cdb_rob_id = 3'd0; cdb_value = 32'h77;
        step();
        cdb_valid = 1'b0;
        flush_in = 1'b1; dec_valid = 1'b1;
        step();
        flush_in = 1'b0; dec_valid = 1'b0;
        q1_rob_id = 3'd0;
        #1;
        chk("flush_no_commit", 32'(commit_valid), 32'd0);
        chk("flush_dec_id", 32'(dec_rob_id), 32'd0);
        chk("flush_full", 32'(rob_full), 32'd0);
        chk("flush_q1_ready", 32'(q1_ready), 32'd0);
        dec_valid = 1'b1; dec_rd = 5'd9;
        step();
        dec_valid = 1'b0;
        chk("post_flush_next_id", 32'(dec_rob_id), 32'd1);
        chk("post_flush_q1_ready", 32'(q1_ready), 32'd0);
        cdb_valid = 1'b1; cdb_rob_id = 3'd0; cdb_value = 32'h99;
        step();
        cdb_valid = 1'b0;
        step();
        expect_commit("post_flush_retire", 3'd0, 5'd9, 32'h99);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
